execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- EX stage of the in-order RV32I pipeline. Accepts decoded instructions from the ID stage over a valid/ready handshake, selects operands, drives one ALU instance, resolves branches and jumps, and registers results into the EX/MEM register for the memory stage.
- Generates the one-cycle fetch redirect.
- Drops the single wrong-path instruction that arrives while the redirect is in flight.

Parameters:
- RESET_PC, 32'h0000_0000: value loaded into out_pc and redirect_pc at reset (debug visibility only).

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  trap/kill from later stages; squashes the EX/MEM register
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  EX accepts this cycle
- in_pc  in  32  instruction PC
- in_rs1, in_rs2  in  32  register operand values (already forwarded)
- in_imm  in  32  sign-extended immediate
- in_alu_op  in  4  ALU_* code from riscvdefs.vh
- in_a_sel  in  1  0: rs1, 1: pc
- in_b_sel  in  1  0: rs2, 1: imm
- in_branch  in  1  conditional branch; funct3 in in_funct3
- in_jal, in_jalr  in  1  jump kinds (mutually exclusive with in_branch)
- in_funct3  in  3  branch condition / memory size, passed through
- in_mem_rd, in_mem_wr  in  1  load/store flags, passed through
- in_rd  in  5  destination register
- in_rd_we  in  1  writeback enable
- out_valid  out  1  EX/MEM register holds an instruction
- out_ready  in  1  MEM stage consumes
- out_pc, out_result, out_store_data  out  32  registered PC, ALU/link result, rs2
- out_funct3  out  3
- out_mem_rd, out_mem_wr, out_rd_we  out  1
- out_rd  out  5
- out_exc_misaligned  out  1  taken target not 4-byte aligned
- redirect_valid  out  1  one-cycle pulse: fetch must jump
- redirect_pc  out  32  target address

Behaviour:
- Reset (async):
  - out_valid=0, redirect_valid=0, shadow=0.
  - All out_* data fields = 0.
  - out_pc and redirect_pc = RESET_PC.
- Operands:
  - A = in_a_sel ? in_pc : in_rs1.
  - B = in_b_sel ? in_imm : in_rs2.
  - ALU op = in_alu_op.
- Branch:
  - ID sets alu_op to ALU_EQ for BEQ/BNE, ALU_SLT for BLT/BGE, ALU_SLTU for BLTU/BGEU, with a_sel=0 and b_sel=0.
  - taken = alu_result[0] XOR in_funct3[0].
  - target = in_pc + in_imm, computed by a dedicated 32-bit adder, wrapping mod 2^32.
- JAL:
  - target = in_pc + in_imm.
  - result = in_pc + 4.
- JALR:
  - target = (in_rs1 + in_imm) & ~32'h1.
  - result = in_pc + 4.
- Result for all other instructions = alu_result.
- Handshake:
  - in_ready = (!out_valid | out_ready) & !flush.
  - Accept = in_valid & in_ready.
  - On accept, EX/MEM loads at the next edge and out_valid=1. Latency is 1 cycle.
  - Out fields hold stable while out_valid & !out_ready.
  - A drain without an accept clears out_valid.
- Redirect:
  - Accepting a taken branch, JAL or JALR with target[1:0]==0 sets redirect_valid=1 and redirect_pc=target for exactly one cycle (registered, aligned with out_valid).
  - The same accept sets shadow=1.
- Shadow:
  - While shadow=1, in_ready is forced to 1 and any in_valid beat is discarded. out_valid is not set and no redirect is issued.
  - shadow clears after one cycle, whether or not a beat arrived.
- Misaligned target (taken, target[1]==1):
  - Instruction enters EX/MEM with out_exc_misaligned=1 and out_rd_we=0.
  - No redirect, no shadow.
- flush:
  - Clears out_valid, redirect_valid and shadow at the next edge.
  - Flush wins over a simultaneous accept; in_ready=0 that cycle.
- Back-pressure (out_valid & !out_ready): in_ready=0, redirect_valid still deasserts after one cycle.
- Reset mid-operation: all state returns to reset values immediately; no partial redirect is emitted.

Decomposition:
- Constants in riscvdefs.vh: ALU_* opcodes (existing), plus new BR_* funct3 codes (BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111).
- Sub-modules:
  - Instantiate the existing ALU as is.
  - Add branch_unit: combinational; takes alu_result[0], funct3, pc, rs1, imm and the jump flags; produces taken, target and misaligned.
- The execute_stage top holds all sequential state: EX/MEM register, redirect register, shadow flag.

Test Plan:
- ADDI: rs1=5, imm=-3, b_sel=1, ALU_ADD -> next cycle out_valid=1, out_result=2, redirect_valid=0.
- BNE, not taken: rs1=rs2=7, pc=0x100, imm=0x20 -> result not written (rd_we=0), redirect_valid=0.
- BNE, taken: rs1=7, rs2=8, pc=0x100, imm=0x20 -> redirect_valid=1 for one cycle with redirect_pc=0x120. The next in_valid beat is accepted and dropped (out_valid=0 the following cycle).
- JALR: rs1=0x203, imm=0 -> redirect_pc=0x202, flagged misaligned. out_exc_misaligned=1, out_rd_we=0, redirect_valid=0.
- Back-pressure: out_ready=0 for 3 cycles with a valid beat held upstream -> in_ready=0 and out_* stable. Beat accepted the cycle after out_ready=1.
- flush asserted in the same cycle as a JAL accept (pc=0xFFFF_FFFC, imm=8) -> no load, redirect_valid=0. Without flush, redirect_pc=0x0000_0004 (wrap).

Source files
------------

// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg: ALU opcodes, branch funct3 codes and the EX/MEM register layout
package execute_stage_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_PASSB = 4'd11;
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [31:0] store_data;
    logic [2:0]  funct3;
    logic        mem_rd;
    logic        mem_wr;
    logic        rd_we;
    logic [4:0]  rd;
    logic        exc_misaligned;
  } exmem_t;
endpackage

// File: rtl/execute_stage_alu.sv
// alu: RV32I integer ALU; ports a, b (operands), op (ALU_* code), result
module alu
  import execute_stage_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] result
);
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << b[4:0];
      ALU_SLT:   result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {31'd0, a < b};
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> b[4:0];
      ALU_SRA:   result = $signed(a) >>> b[4:0];
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_EQ:    result = {31'd0, a == b};
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end
endmodule

// File: rtl/execute_stage_branch_unit.sv
// branch_unit: branch/jump resolution; ports alu_lsb, invert (funct3[0]), pc, rs1, imm, branch/jal/jalr in; taken, target, misaligned out
module branch_unit (
  input  logic        alu_lsb,
  input  logic        invert,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] imm,
  input  logic        branch,
  input  logic        jal,
  input  logic        jalr,
  output logic        taken,
  output logic [31:0] target,
  output logic        misaligned
);
  logic [31:0] sum;
  // one adder serves all three kinds; JALR swaps the base and clears bit 0
  assign sum        = (jalr ? rs1 : pc) + imm;
  assign target     = {sum[31:1], sum[0] & ~jalr};
  assign taken      = jal | jalr | (branch & (alu_lsb ^ invert));
  assign misaligned = taken & |target[1:0];
endmodule

// File: rtl/execute_stage.sv
// execute_stage: RV32I EX stage; ID handshake in, EX/MEM register out, one-cycle fetch redirect, wrong-path shadow drop
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_imm,
  input  logic [3:0]  in_alu_op,
  input  logic        in_a_sel,
  input  logic        in_b_sel,
  input  logic        in_branch,
  input  logic        in_jal,
  input  logic        in_jalr,
  input  logic [2:0]  in_funct3,
  input  logic        in_mem_rd,
  input  logic        in_mem_wr,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_we,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_result,
  output logic [31:0] out_store_data,
  output logic [2:0]  out_funct3,
  output logic        out_mem_rd,
  output logic        out_mem_wr,
  output logic        out_rd_we,
  output logic [4:0]  out_rd,
  output logic        out_exc_misaligned,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);
  logic [31:0] alu_result, target;
  logic        taken, misaligned, shadow, accept, redirect;
  exmem_t      ex, ex_d;
  alu u_alu (
    .a(in_a_sel ? in_pc : in_rs1),
    .b(in_b_sel ? in_imm : in_rs2),
    .op(in_alu_op),
    .result(alu_result)
  );
  branch_unit u_br (
    .alu_lsb(alu_result[0]),
    .invert(in_funct3[0]),
    .pc(in_pc),
    .rs1(in_rs1),
    .imm(in_imm),
    .branch(in_branch),
    .jal(in_jal),
    .jalr(in_jalr),
    .taken(taken),
    .target(target),
    .misaligned(misaligned)
  );
  // the shadow cycle always takes the beat so the wrong-path instruction is swallowed
  assign in_ready = !flush & (shadow | !out_valid | out_ready);
  assign accept   = in_valid & in_ready & !shadow;
  assign redirect = accept & taken & !misaligned;
  assign ex_d = '{
    pc:             in_pc,
    result:         (in_jal | in_jalr) ? in_pc + 32'd4 : alu_result,
    store_data:     in_rs2,
    funct3:         in_funct3,
    mem_rd:         in_mem_rd,
    mem_wr:         in_mem_wr,
    rd_we:          in_rd_we & !misaligned,
    rd:             in_rd,
    exc_misaligned: misaligned
  };
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex             <= '0;
      ex.pc          <= RESET_PC;
      out_valid      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= RESET_PC;
      shadow         <= 1'b0;
    end else if (flush) begin
      out_valid      <= 1'b0;
      redirect_valid <= 1'b0;
      shadow         <= 1'b0;
    end else begin
      redirect_valid <= redirect;
      shadow         <= redirect;
      if (accept & taken) redirect_pc <= target;
      if (accept) begin
        ex        <= ex_d;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
  assign out_pc             = ex.pc;
  assign out_result         = ex.result;
  assign out_store_data     = ex.store_data;
  assign out_funct3         = ex.funct3;
  assign out_mem_rd         = ex.mem_rd;
  assign out_mem_wr         = ex.mem_wr;
  assign out_rd_we          = ex.rd_we;
  assign out_rd             = ex.rd;
  assign out_exc_misaligned = ex.exc_misaligned;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed self-checking bench for execute_stage
module tb_execute_stage;
  import execute_stage_pkg::*;
  localparam logic [31:0] RPC = 32'h0000_1000;
  logic        clk, reset, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
  logic [3:0]  in_alu_op;
  logic        in_a_sel, in_b_sel, in_branch, in_jal, in_jalr;
  logic [2:0]  in_funct3;
  logic        in_mem_rd, in_mem_wr, in_rd_we;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_result, out_store_data;
  logic [2:0]  out_funct3;
  logic        out_mem_rd, out_mem_wr, out_rd_we, out_exc_misaligned;
  logic [4:0]  out_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  int checks = 0;
  int errors = 0;

  execute_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_alu_op(in_alu_op), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
    .in_branch(in_branch), .in_jal(in_jal), .in_jalr(in_jalr),
    .in_funct3(in_funct3), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_result(out_result), .out_store_data(out_store_data),
    .out_funct3(out_funct3), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_rd_we(out_rd_we), .out_rd(out_rd), .out_exc_misaligned(out_exc_misaligned),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, rs1, rs2, imm, input logic [3:0] op,
                       input logic a_sel, b_sel, br, jal, jalr, input logic [2:0] f3,
                       input logic [4:0] rd, input logic rd_we);
    in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_alu_op = op;
    in_a_sel = a_sel; in_b_sel = b_sel; in_branch = br; in_jal = jal; in_jalr = jalr;
    in_funct3 = f3; in_rd = rd; in_rd_we = rd_we; in_mem_rd = 1'b0; in_mem_wr = 1'b0;
    in_valid = 1'b1;
  endtask

  task automatic drive_addi();
    drive(32'h40, 32'd5, 32'd0, -32'sd3, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 5'd3, 1'b1);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redirect_valid: got %b want 0", redirect_valid); end
    checks++; if (out_pc !== RPC) begin errors++; $display("FAIL reset_out_pc: got %h want %h", out_pc, RPC); end
    checks++; if (redirect_pc !== RPC) begin errors++; $display("FAIL reset_redirect_pc: got %h want %h", redirect_pc, RPC); end
    checks++; if (out_result !== 32'd0 || out_rd_we !== 1'b0) begin errors++; $display("FAIL reset_fields: result %h rd_we %b want 0/0", out_result, out_rd_we); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_addi();
    drive_addi();
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    checks++; if (out_result !== 32'd2) begin errors++; $display("FAIL addi_result: got %h want 2", out_result); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL addi_redirect: got %b want 0", redirect_valid); end
    checks++; if (out_rd !== 5'd3 || out_rd_we !== 1'b1 || out_pc !== 32'h40) begin errors++; $display("FAIL addi_fields: rd %0d we %b pc %h want 3/1/40", out_rd, out_rd_we, out_pc); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_bne_not_taken();
    drive(32'h100, 32'd7, 32'd7, 32'h20, ALU_EQ, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BR_BNE, 5'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rd_we !== 1'b0) begin errors++; $display("FAIL bne_nt_out: valid %b rd_we %b want 1/0", out_valid, out_rd_we); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL bne_nt_redirect: got %b want 0", redirect_valid); end
    tick();
  endtask

  task automatic test_bne_taken();
    drive(32'h100, 32'd7, 32'd8, 32'h20, ALU_EQ, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BR_BNE, 5'd0, 1'b0);
    tick();
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL bne_t_redirect: got %b want 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h120) begin errors++; $display("FAIL bne_t_redirect_pc: got %h want 120", redirect_pc); end
    drive_addi();
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL shadow_in_ready: got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL shadow_drop: out_valid %b want 0", out_valid); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL bne_t_pulse: redirect_valid %b want 0", redirect_valid); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd2) begin errors++; $display("FAIL shadow_clear: valid %b result %h want 1/2", out_valid, out_result); end
    tick();
  endtask

  task automatic test_jalr_misaligned();
    drive(32'h200, 32'h203, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 5'd1, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b1 || out_exc_misaligned !== 1'b1) begin errors++; $display("FAIL jalr_mis_flag: valid %b exc %b want 1/1", out_valid, out_exc_misaligned); end
    checks++; if (out_rd_we !== 1'b0) begin errors++; $display("FAIL jalr_mis_rd_we: got %b want 0", out_rd_we); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL jalr_mis_redirect: got %b want 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h202) begin errors++; $display("FAIL jalr_mis_target: got %h want 202", redirect_pc); end
    checks++; if (out_result !== 32'h204) begin errors++; $display("FAIL jalr_mis_link: got %h want 204", out_result); end
    drive_addi();
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_exc_misaligned !== 1'b0 || out_result !== 32'd2) begin errors++; $display("FAIL jalr_no_shadow: valid %b exc %b result %h want 1/0/2", out_valid, out_exc_misaligned, out_result); end
    tick();
  endtask

  task automatic test_back_pressure();
    drive(32'h10, 32'd10, 32'd0, 32'd1, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 5'd4, 1'b1);
    tick();
    out_ready = 1'b0;
    drive(32'h14, 32'd20, 32'd0, 32'd2, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_result !== 32'd11 || out_rd !== 5'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d: valid %b result %h rd %0d in_ready %b want 1/b/4/0", i, out_valid, out_result, out_rd, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd22) begin errors++; $display("FAIL bp_accept: valid %b result %h want 1/16", out_valid, out_result); end
    drive(32'h300, 32'd0, 32'd0, 32'h10, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 5'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h310 || out_result !== 32'h304) begin errors++; $display("FAIL bp_jal: redir %b pc %h result %h want 1/310/304", redirect_valid, redirect_pc, out_result); end
    tick();
    checks++; if (redirect_valid !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h304) begin errors++; $display("FAIL bp_redirect_pulse: redir %b valid %b result %h want 0/1/304", redirect_valid, out_valid, out_result); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_flush_jal();
    drive(32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 5'd1, 1'b1);
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL flush_no_load: valid %b redir %b want 0/0", out_valid, redirect_valid); end
    tick();
    in_valid = 1'b0;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4) begin errors++; $display("FAIL jal_wrap: redir %b pc %h want 1/4", redirect_valid, redirect_pc); end
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h0) begin errors++; $display("FAIL jal_wrap_link: valid %b result %h want 1/0", out_valid, out_result); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(32'h400, 32'd0, 32'd0, 32'h40, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 5'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: redir %b want 1", redirect_valid); end
    #1 reset = 1'b1;
    #1;
    checks++; if (redirect_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset: redir %b valid %b want 0/0", redirect_valid, out_valid); end
    checks++; if (redirect_pc !== RPC || out_pc !== RPC) begin errors++; $display("FAIL mid_reset_pc: redir_pc %h out_pc %h want %h", redirect_pc, out_pc, RPC); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++; if (redirect_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_after: redir %b valid %b want 0/0", redirect_valid, out_valid); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(32'd0, 32'd0, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    in_valid = 1'b0;
    test_reset();
    test_addi();
    test_bne_not_taken();
    test_bne_taken();
    test_jalr_misaligned();
    test_back_pressure();
    test_flush_jal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
